// File: rtl/enumeration_pkg.sv
// Shared t_family encoding, FSM state type and ordinal helpers for the
// value-to-member lookup and the enumeration test module.
package enumeration_pkg;

    localparam int NUM = 15;
    localparam logic [3:0] LAST_ORD = 4'(NUM - 1);

    typedef enum int {
        father = 0, mother = 1, son0 = 2, son1 = 3, daughter = 4, gerbil = 5,
        dog0 = 10, dog1 = 11, dog2 = 12,
        cat3 = 20, cat4 = 21, cat5 = 22,
        car3 = 30, car2 = 31, car1 = 32
    } t_family;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} t_state;

    // Single source of the ordinal order; family_rom reads the same table.
    function automatic t_family family_at(input logic [3:0] index);
        t_family f;
        case (index)
            4'd0:    f = father;
            4'd1:    f = mother;
            4'd2:    f = son0;
            4'd3:    f = son1;
            4'd4:    f = daughter;
            4'd5:    f = gerbil;
            4'd6:    f = dog0;
            4'd7:    f = dog1;
            4'd8:    f = dog2;
            4'd9:    f = cat3;
            4'd10:   f = cat4;
            4'd11:   f = cat5;
            4'd12:   f = car3;
            4'd13:   f = car2;
            4'd14:   f = car1;
            default: f = father;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] family_ordinal(input t_family f);
        logic [3:0] ord;
        ord = 4'd0;
        for (int k = 0; k < NUM; k++) begin
            if (family_at(4'(k)) == f) ord = 4'(k);
        end
        return ord;
    endfunction

    function automatic t_family family_next(input t_family f);
        logic [3:0] ord;
        ord = family_ordinal(f);
        return (ord == LAST_ORD) ? family_at(4'd0) : family_at(ord + 4'd1);
    endfunction

    function automatic t_family family_prev(input t_family f);
        logic [3:0] ord;
        ord = family_ordinal(f);
        return (ord == 4'd0) ? family_at(LAST_ORD) : family_at(ord - 4'd1);
    endfunction

endpackage

// File: rtl/family_rom.sv
// Combinational ordinal-to-encoding table; all encodings fit in six bits.
module family_rom
    import enumeration_pkg::*;
(
    input  logic [3:0] ord_i,
    output logic [5:0] enc_o
);

    assign enc_o = 6'(int'(family_at(ord_i)));

endmodule

// File: rtl/family_lookup.sv
// Value-to-member lookup: walks t_family one member per cycle, forward or
// backward, and reports the matching ordinal or a miss after NUM compares.
module family_lookup
    import enumeration_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_value,
    input  logic          req_back,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_hit,
    output logic [3:0]    rsp_index,
    output t_family       rsp_member,
    output logic [3:0]    rsp_steps
);

    t_state     state_q;
    logic [3:0] cursor_q;
    logic [3:0] cursor_d;
    logic [3:0] count_q;
    logic [5:0] valueLow_q;
    logic       inRange_q;
    logic       back_q;
    logic       hit_q;
    logic [3:0] index_q;
    t_family    member_q;
    logic [3:0] steps_q;
    logic [5:0] romEnc;
    logic       match;

    family_rom uRom (
        .ord_i (cursor_q),
        .enc_o (romEnc)
    );

    // Anything with bits set above bit 5 was flagged at accept and can never match.
    assign match     = inRange_q && (valueLow_q == romEnc);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_hit    = hit_q;
    assign rsp_index  = index_q;
    assign rsp_member = member_q;
    assign rsp_steps  = steps_q;

    always_comb begin
        cursor_d = cursor_q;
        if (back_q) begin
            cursor_d = (cursor_q == 4'd0) ? LAST_ORD : cursor_q - 4'd1;
        end else begin
            cursor_d = (cursor_q == LAST_ORD) ? 4'd0 : cursor_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cursor_q   <= 4'd0;
            count_q    <= 4'd0;
            valueLow_q <= 6'd0;
            inRange_q  <= 1'b0;
            back_q     <= 1'b0;
            hit_q      <= 1'b0;
            index_q    <= 4'd0;
            member_q   <= father;
            steps_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        valueLow_q <= req_value[5:0];
                        inRange_q  <= (req_value[DW-1:6] == '0);
                        back_q     <= req_back;
                        cursor_q   <= req_back ? LAST_ORD : 4'd0;
                        count_q    <= 4'd1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        hit_q    <= 1'b1;
                        index_q  <= cursor_q;
                        member_q <= family_at(cursor_q);
                        steps_q  <= count_q;
                        state_q  <= DONE;
                    end else if (count_q == 4'(NUM)) begin
                        hit_q    <= 1'b0;
                        index_q  <= 4'd0;
                        member_q <= father;
                        steps_q  <= 4'(NUM);
                        state_q  <= DONE;
                    end else begin
                        cursor_q <= cursor_d;
                        count_q  <= count_q + 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/family_lookup.md
# family_lookup

Inverse of the enumeration method walk: accepts a raw integer, scans the sparse `t_family` encoding one member per cycle, using first/next semantics forward or last/prev semantics backward, and returns the member's ordinal index, or reports a miss. It sits next to the enumeration test module as the hardware "value → member" direction of the same `t_family` type. It gives the bench a cycle-accurate reference for how enum stepping maps to encodings.

## Interface
Parameters:
- `DW`, 32: width of the raw request value; matches `int`.

Ports:
- `clk` in 1: clock. One clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request; high only in IDLE.
- `req_value` in DW: raw integer to look up.
- `req_back` in 1: 0 = scan first→last via next; 1 = scan last→first via prev.
- `rsp_valid` out 1: result present; held until taken.
- `rsp_ready` in 1: consumer takes result.
- `rsp_hit` out 1: value is a legal `t_family` encoding.
- `rsp_index` out 4: ordinal of matched member, 0..14; 0 on miss.
- `rsp_member` out `t_family`: matched member; `father` on miss.
- `rsp_steps` out 4: number of members compared, 1..15.

## Operation
- Encoding, fixed in package:
  - father=0, mother=1, son0=2, son1=3, daughter=4, gerbil=5
  - dog0=10, dog1=11, dog2=12
  - cat3=20, cat4=21, cat5=22
  - car3=30, car2=31, car1=32
  - NUM=15.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_value` and `req_back`.
  - Cursor := first (ordinal 0) if forward, last (ordinal 14) if back.
  - Count := 1. Go to SCAN.
- SCAN:
  - Each cycle, compare the cursor encoding to the latched value, zero-extended to DW. Values with nonzero bits above bit 5 never match.
  - Match: capture hit=1, index=cursor, steps=count. Go to DONE.
  - No match with count==NUM: hit=0, index=0, member=father, steps=15. Go to DONE.
  - Otherwise: cursor := next (forward) or prev (back), count+1. Next/prev wrap at the ends (car1→father, father→car1). Wrap is never reached within one scan, since the count limit stops first.
- DONE:
  - `rsp_valid`=1, outputs stable.
  - On `rsp_ready`, go to IDLE.
  - A `req_valid` in the same cycle is not accepted (`req_ready`=0).
- Encodings are unique, so forward and back scans of the same value give the same index and member. Only `rsp_steps` differs: forward k+1, back 15−k.

## Timing
- Reset value of every output:
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_hit`=0, `rsp_index`=0, `rsp_member`=father, `rsp_steps`=0.
- Reset mid-SCAN or mid-DONE:
  - Immediate return to IDLE, outputs at reset values.
  - No response is ever issued for the aborted request.
- Latency from accept edge to first `rsp_valid` cycle equals `rsp_steps` cycles. Forward hit at ordinal k: k+1. Miss: 15.
- Throughput: one request per steps+2 cycles minimum (accept, scan, DONE with `rsp_ready`=1).
- `rsp_*` registered; no combinational path from `req_*` to `rsp_*`.
- `req_value` / `req_back` are sampled only at the accept edge. Later changes are ignored.

## Structure
- Package `enumeration_pkg` holds:
  - `typedef enum int t_family` with the encodings above.
  - `localparam NUM=15`.
  - Function `family_at(index)` returning the member at an ordinal.
  - Functions `family_next` / `family_prev` with wrap.
- One sub-module, `family_rom`: combinational ordinal→encoding table used by the SCAN compare. It must be the same table the package functions use.
- FSM, cursor, counter and response registers live in `family_lookup`.

## Test plan
- Reset, then forward requests for 0, 5, 10, 32 → hit, index 0/5/6/14, steps 1/6/7/15, member father/gerbil/dog0/car1.
- Back requests for 32 and 0 → index 14 steps 1; index 0 steps 15.
- Gap values 6, 13, 23, 33, 0xFFFF_FFE0, forward and back → hit=0, index=0, member=father, steps=15.
- `rsp_ready` held low 5 cycles in DONE → `rsp_*` stable, `req_ready`=0. New `req_valid` ignored until the response is taken.
- Assert `rst` on the 3rd SCAN cycle of a request for 31 → outputs at reset values next edge, no `rsp_valid`. A following request for 21 returns index 10, steps 11.
- Sweep all 15 members back-to-back with `rsp_ready`=1 → response order matches requests, and `rsp_member` equals `family_at(rsp_index)` every time.
